// File: rtl/adc_seq_pkg.sv
// Shared types and defaults for the ADC slice sequencer.
// Used by adc_slice_sequencer and adc_seq_timer.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_ENABLE    = 3'd2,
        ST_SYNC      = 3'd3,
        ST_WAIT_LOCK = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    localparam int DEF_RST_CYCLES   = 8;
    localparam int DEF_SYNC_TIMEOUT = 255;
    localparam int MAX_INIT_W       = 1024;

    // Slice i gets i mod 2^ndiv, i.e. the low ndiv bits of its own index.
    function automatic logic [MAX_INIT_W-1:0] stagger_init(input int nti, input int ndiv);
        logic [MAX_INIT_W-1:0] v;
        logic [9:0]            idx;
        v = {MAX_INIT_W{1'b0}};
        for (int i = 0; i < nti; i++) begin
            for (int b = 0; b < ndiv; b++) begin
                idx    = 10'(i * ndiv + b);
                v[idx] = 1'((i >> b) & 1);
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// Saturating cycle counter with synchronous clear and terminal-count
// compare against a caller-selected limit.
module adc_seq_timer
    import adc_seq_pkg::*;
#(
    parameter int Nw = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic [Nw-1:0] i_limit,
    output logic          o_tc
);

    logic [Nw-1:0] r_count;

    // Count up from zero after a clear, holding at all-ones instead of wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= {Nw{1'b0}};
        end else if (i_clr) begin
            r_count <= {Nw{1'b0}};
        end else if (r_count != {Nw{1'b1}}) begin
            r_count <= r_count + {{(Nw-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_tc = (r_count >= i_limit);

endmodule

// File: rtl/adc_slice_sequencer.sv
// Startup/shutdown sequencer for the interleaved stochastic ADC slice bank.
// Define ADC_SEQ_STAGGER_INIT_EN to derive divider phases from slice index.
module adc_slice_sequencer
    import adc_seq_pkg::*;
#(
    parameter int Nti          = 16,
    parameter int Ndiv         = 2,
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int SYNC_TIMEOUT = DEF_SYNC_TIMEOUT,
    parameter int Nw           = 8
) (
    input  logic                emu_clk,
    input  logic                emu_rst,
    input  logic                start,
    input  logic                stop,
    input  logic                negedge_clk_in,
    input  logic [Nti-1:0]      slice_mask,
    input  logic [Nti*Ndiv-1:0] init_cfg,
    input  logic [Nti-1:0]      en_sync_out,
    output logic                rstb,
    output logic [Nti-1:0]      en_slice,
    output logic                en_sync_in,
    output logic [Nti*Ndiv-1:0] init,
    output logic                running,
    output logic                fault,
    output logic [2:0]          state_o
);

    state_t                r_state;
    state_t                w_next;
    logic [Nti-1:0]        r_mask;
    logic [Nti*Ndiv-1:0]   r_init;
    logic [Nti*Ndiv-1:0]   w_init_src;
    logic [Nti*Ndiv-1:0]   w_init_masked;
    logic                  w_accept;
    logic                  w_lock;
    logic                  w_tc;
    logic                  w_clr;
    logic [Nw-1:0]         w_limit;
    logic                  r_rstb,  w_rstb;
    logic [Nti-1:0]        r_en_slice, w_en_slice;
    logic                  r_en_sync_in, w_en_sync_in;
    logic                  r_running, w_running;
    logic                  r_fault, w_fault;

`ifdef ADC_SEQ_STAGGER_INIT_EN
    assign w_init_src = (Nti*Ndiv)'(stagger_init(Nti, Ndiv));
`else
    assign w_init_src = init_cfg;
`endif

    // Unmasked slices always carry a zero divider init.
    for (genvar gi = 0; gi < Nti; gi++) begin : g_init_mask
        assign w_init_masked[gi*Ndiv +: Ndiv] = w_init_src[gi*Ndiv +: Ndiv] & {Ndiv{slice_mask[gi]}};
    end

    assign w_accept = start & ~stop & ((r_state == ST_IDLE) | (r_state == ST_FAULT));
    assign w_lock   = ((en_sync_out & r_mask) == r_mask);
    assign w_clr    = (w_next != r_state);
    // Limits are one less than the dwell because the count starts at zero on entry.
    assign w_limit  = (r_state == ST_RESET) ? Nw'(RST_CYCLES - 1) : Nw'(SYNC_TIMEOUT - 1);

    adc_seq_timer #(.Nw(Nw)) u_timer (
        .i_clk   (emu_clk),
        .i_rst   (emu_rst),
        .i_clr   (w_clr),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    // State register plus output registers decoded from the upcoming state.
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            r_state      <= ST_IDLE;
            r_rstb       <= 1'b0;
            r_en_slice   <= {Nti{1'b0}};
            r_en_sync_in <= 1'b0;
            r_running    <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_rstb       <= w_rstb;
            r_en_slice   <= w_en_slice;
            r_en_sync_in <= w_en_sync_in;
            r_running    <= w_running;
            r_fault      <= w_fault;
        end
    end

    // Slice mask and divider init are captured only on an accepted start.
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            r_mask <= {Nti{1'b0}};
            r_init <= {(Nti*Ndiv){1'b0}};
        end else if (w_accept) begin
            r_mask <= slice_mask;
            r_init <= w_init_masked;
        end else begin
            r_mask <= r_mask;
            r_init <= r_init;
        end
    end

    // Next-state logic; stop overrides every other transition.
    always_comb begin
        w_next = r_state;
        if (stop) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_FAULT: begin
                    if (start) begin
                        w_next = (slice_mask == {Nti{1'b0}}) ? ST_FAULT : ST_RESET;
                    end else begin
                        w_next = r_state;
                    end
                end
                ST_RESET:     w_next = w_tc ? ST_ENABLE : ST_RESET;
                ST_ENABLE:    w_next = ST_SYNC;
                ST_SYNC:      w_next = negedge_clk_in ? ST_WAIT_LOCK : ST_SYNC;
                ST_WAIT_LOCK: begin
                    if (w_lock) begin
                        w_next = ST_RUN;
                    end else if (w_tc) begin
                        w_next = ST_FAULT;
                    end else begin
                        w_next = ST_WAIT_LOCK;
                    end
                end
                ST_RUN:       w_next = w_lock ? ST_RUN : ST_FAULT;
                default:      w_next = ST_IDLE;
            endcase
        end
    end

    // Output decode of the state being entered, so registered outputs track state_o.
    always_comb begin
        w_rstb       = 1'b0;
        w_en_slice   = {Nti{1'b0}};
        w_en_sync_in = 1'b0;
        w_running    = 1'b0;
        w_fault      = 1'b0;
        case (w_next)
            ST_ENABLE, ST_SYNC: begin
                w_rstb     = 1'b1;
                w_en_slice = r_mask;
            end
            ST_WAIT_LOCK: begin
                w_rstb       = 1'b1;
                w_en_slice   = r_mask;
                w_en_sync_in = 1'b1;
            end
            ST_RUN: begin
                w_rstb       = 1'b1;
                w_en_slice   = r_mask;
                w_en_sync_in = 1'b1;
                w_running    = 1'b1;
            end
            ST_FAULT: w_fault = 1'b1;
            default:  w_rstb  = 1'b0;
        endcase
    end

    assign rstb       = r_rstb;
    assign en_slice   = r_en_slice;
    assign en_sync_in = r_en_sync_in;
    assign init       = r_init;
    assign running    = r_running;
    assign fault      = r_fault;
    assign state_o    = r_state;

endmodule

// File: tb/tb_adc_slice_sequencer.sv
// Directed self-checking bench for adc_slice_sequencer (Nti=4, Ndiv=2).
module tb_adc_slice_sequencer;

    localparam int NTI  = 4;
    localparam int NDIV = 2;

    localparam logic [2:0] S_IDLE = 3'd0, S_RESET = 3'd1, S_ENABLE = 3'd2, S_SYNC = 3'd3,
                           S_WAIT = 3'd4, S_RUN = 3'd5, S_FAULT = 3'd6;

    logic            emu_clk = 1'b0;
    logic            emu_rst = 1'b1;
    logic            start = 1'b0, stop = 1'b0, negedge_clk_in = 1'b0;
    logic [NTI-1:0]  slice_mask = 4'h0;
    logic [7:0]      init_cfg = 8'h00;
    logic [NTI-1:0]  en_sync_out = 4'h0;
    logic            rstb, en_sync_in, running, fault;
    logic [NTI-1:0]  en_slice;
    logic [7:0]      init;
    logic [2:0]      state_o;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    adc_slice_sequencer #(.Nti(NTI), .Ndiv(NDIV)) dut (
        .emu_clk(emu_clk), .emu_rst(emu_rst), .start(start), .stop(stop),
        .negedge_clk_in(negedge_clk_in), .slice_mask(slice_mask), .init_cfg(init_cfg),
        .en_sync_out(en_sync_out), .rstb(rstb), .en_slice(en_slice), .en_sync_in(en_sync_in),
        .init(init), .running(running), .fault(fault), .state_o(state_o)
    );

    always #5 emu_clk = ~emu_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge emu_clk);
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic rb,
                              input logic [3:0] ens, input logic esi, input logic run, input logic flt);
        check({tag, ".state"}, 32'(state_o), 32'(st));
        check({tag, ".rstb"}, 32'(rstb), 32'(rb));
        check({tag, ".en_slice"}, 32'(en_slice), 32'(ens));
        check({tag, ".en_sync_in"}, 32'(en_sync_in), 32'(esi));
        check({tag, ".running"}, 32'(running), 32'(run));
        check({tag, ".fault"}, 32'(fault), 32'(flt));
    endtask

    task automatic pulse_start(input logic [3:0] m, input logic [7:0] cfg);
        slice_mask = m; init_cfg = cfg; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int bound);
        for (int i = 0; i < bound && state_o != st; i++) step();
        check(tag, 32'(state_o), 32'(st));
    endtask

    // From SYNC: strobe one clk_in falling edge so the DUT enters WAIT_LOCK.
    task automatic strobe_sync();
        negedge_clk_in = 1'b1;
        step();
        negedge_clk_in = 1'b0;
    endtask

    initial begin
        step(); step();
        check_outs("reset", S_IDLE, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("reset.init", 32'(init), 32'h0);
        emu_rst = 1'b0;
        step();

        // Nominal startup
        pulse_start(4'hF, 8'hE4);
        check_outs("nom.reset", S_RESET, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("nom.init", 32'(init), 32'hE4);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (state_o == S_RESET && rstb == 1'b0) n++;
            else break;
        end
        check("nom.rst_len", 32'(n), 32'd8);
        check_outs("nom.enable", S_ENABLE, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        step(); step(); step();
        check_outs("nom.sync_wait", S_SYNC, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        strobe_sync();
        check_outs("nom.wait_lock", S_WAIT, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
        en_sync_out = 4'hF;
        step();
        check_outs("nom.run", S_RUN, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        check("nom.start_ignored", 32'(state_o), 32'(S_RUN));

        // Sync loss in RUN
        en_sync_out = 4'hD;
        step();
        check_outs("loss.fault", S_FAULT, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        pulse_stop();
        check_outs("loss.stop", S_IDLE, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Partial mask: slices 1/3 get zero init and no enable
        en_sync_out = 4'h0;
        pulse_start(4'h5, 8'hFF);
        check("part.init", 32'(init), 32'h33);
        wait_state("part.sync", S_SYNC, 30);
        check("part.en_slice", 32'(en_slice), 32'h5);
        strobe_sync();
        en_sync_out = 4'h5;
        step();
        check_outs("part.run", S_RUN, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0);
        pulse_stop();

        // Timeout: slice 3 never acknowledges
        en_sync_out = 4'h7;
        pulse_start(4'hF, 8'hE4);
        wait_state("tmo.sync", S_SYNC, 30);
        strobe_sync();
        n = 0;
        for (int i = 0; i < 400 && state_o == S_WAIT; i++) begin
            n++;
            step();
        end
        check("tmo.len", 32'(n), 32'd255);
        check_outs("tmo.fault", S_FAULT, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        en_sync_out = 4'hF;
        pulse_start(4'hF, 8'hE4);
        check("tmo.restart", 32'(state_o), 32'(S_RESET));
        wait_state("tmo.sync2", S_SYNC, 30);
        strobe_sync();
        step();
        check_outs("tmo.run2", S_RUN, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
        pulse_stop();

        // Lock arrives in the very cycle the timeout would fire
        en_sync_out = 4'h7;
        pulse_start(4'hF, 8'hE4);
        wait_state("tie.sync", S_SYNC, 30);
        strobe_sync();
        for (int i = 0; i < 254; i++) step();
        check("tie.still_wait", 32'(state_o), 32'(S_WAIT));
        en_sync_out = 4'hF;
        step();
        check("tie.run", 32'(state_o), 32'(S_RUN));
        pulse_stop();

        // start and stop together in IDLE
        slice_mask = 4'hF; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check_outs("prio.idle", S_IDLE, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Empty mask goes straight to FAULT
        pulse_start(4'h0, 8'hE4);
        check("empty.fault", 32'(state_o), 32'(S_FAULT));
        pulse_stop();

        // Asynchronous reset during WAIT_LOCK
        en_sync_out = 4'h0;
        pulse_start(4'hF, 8'hE4);
        wait_state("arst.sync", S_SYNC, 30);
        strobe_sync();
        check("arst.wait", 32'(state_o), 32'(S_WAIT));
        #2 emu_rst = 1'b1;
        #1;
        check_outs("arst", S_IDLE, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("arst.init", 32'(init), 32'h0);
        step();
        emu_rst = 1'b0;
        step();

        // Stagger feature: init_cfg zero
        pulse_start(4'hF, 8'h00);
`ifdef ADC_SEQ_STAGGER_INIT_EN
        check("stagger.init", 32'(init), 32'hE4);
`else
        check("stagger.init", 32'(init), 32'h00);
`endif
        pulse_stop();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_slice_sequencer.md
Name: adc_slice_sequencer

Overview:
- Startup/shutdown controller for the bank of time-interleaved stochastic ADC slices in the FPGA emulation of the analog core.
- Drives each slice's rstb, en_slice, en_sync_in and init (divider phase) inputs.
- Launches the sync pulse on a clk_in falling edge, waits for every enabled slice to report en_sync_out, then declares the bank running.
- Sits between the JTAG/config register file and the analog_core slice array; runs on emu_clk.

Parameters:
- Nti, 16, number of ADC slices sequenced.
- Ndiv, 2, width of each slice's divider init value.
- RST_CYCLES, 8, emu_clk cycles rstb is held low in RESET (>=1).
- SYNC_TIMEOUT, 255, emu_clk cycles allowed in WAIT_LOCK before FAULT (>=1).
- Nw, 8, width of internal cycle counter; must hold max(RST_CYCLES, SYNC_TIMEOUT).

Ports:
- emu_clk  in  1  emulator clock
- emu_rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin startup; honoured only in IDLE or FAULT
- stop  in  1  one-cycle request to return to IDLE from any state
- negedge_clk_in  in  1  one-cycle strobe, clk_in falling edge detected in emu_clk domain
- slice_mask  in  Nti  1 = slice participates; sampled on accepted start
- init_cfg  in  Nti*Ndiv  per-slice init, slice i at bits [i*Ndiv +: Ndiv]; sampled on accepted start
- en_sync_out  in  Nti  per-slice sync acknowledge from slices
- rstb  out  1  active-low slice reset, common to all slices
- en_slice  out  Nti  per-slice enable
- en_sync_in  out  1  common sync request
- init  out  Nti*Ndiv  per-slice divider init, registered
- running  out  1  high only in RUN
- fault  out  1  high only in FAULT
- state_o  out  3  current state encoding

Behaviour:
- All outputs registered. Reset values: rstb=0, en_slice=0, en_sync_in=0, init=0, running=0, fault=0, state_o=IDLE.
- States (3-bit encoding): IDLE=0, RESET=1, ENABLE=2, SYNC=3, WAIT_LOCK=4, RUN=5, FAULT=6.
- IDLE: rstb=0, en_slice=0, en_sync_in=0. On start, latch slice_mask→mask_q and init_cfg→init; go to RESET; counter cleared.
- RESET: rstb=0 for exactly RST_CYCLES cycles, then go to ENABLE with rstb=1.
- ENABLE: en_slice=mask_q for one cycle, then go to SYNC.
- SYNC: wait for negedge_clk_in. In that same cycle, register en_sync_in=1 and go to WAIT_LOCK with counter cleared.
- WAIT_LOCK:
  - en_sync_in stays 1.
  - When (en_sync_out & mask_q) == mask_q, go to RUN.
  - Otherwise, when counter reaches SYNC_TIMEOUT, go to FAULT.
  - If lock and timeout coincide, lock wins.
- RUN: running=1. All enables hold. Sync loss (any masked en_sync_out low) goes to FAULT.
- FAULT: fault=1, en_slice=0, en_sync_in=0, rstb=0. Only start (restart) or stop exits.
- stop has priority over every transition, including a simultaneous start. Next cycle: IDLE with IDLE output values.
- start outside IDLE/FAULT is ignored.
- mask_q==0 on start: go straight to FAULT (empty bank).
- Unmasked slices: en_slice=0 and init=0 at all times.
- Counter saturates; it never wraps.
- emu_rst asserted mid-operation: immediate return to reset values.

Optional Feature:
- Macro: ADC_SEQ_STAGGER_INIT_EN.
- Defined: init_cfg is ignored. On start, init for slice i = i mod 2^Ndiv, so divider phases are staggered automatically.
- Undefined: init comes from init_cfg as latched.
- Ports are identical in both cases.

Decomposition:
- Shared package adc_seq_pkg holds:
  - the state enum typedef (3 bits) and its encodings;
  - the default RST_CYCLES/SYNC_TIMEOUT localparams;
  - a function computing the staggered init vector.
- One natural sub-module, adc_seq_timer: a saturating Nw-bit cycle counter with clear and terminal-count compare against a selectable limit.

Test Plan:
- Nominal startup: Nti=4, mask=4'b1111, init_cfg=8'hE4, start. Required response:
  - rstb low 8 cycles;
  - en_slice=1111;
  - en_sync_in rises the cycle after the first negedge_clk_in strobe;
  - en_sync_out=1111 gives running=1 next cycle;
  - init=8'hE4.
- Partial mask: mask=4'b0101, only slices 0 and 2 acknowledge → RUN. Required response: en_slice=0101 and init bits for slices 1/3 are 0.
- Timeout: slice 3 never acknowledges → FAULT after exactly 255 cycles in WAIT_LOCK; fault=1, rstb=0. A second start restarts cleanly to RUN.
- Sync loss: in RUN, drop en_sync_out[1] → FAULT next cycle, outputs as FAULT.
- Priority and edges:
  - start and stop in the same IDLE cycle → stays IDLE;
  - lock and timeout in the same cycle → RUN;
  - emu_rst pulse during WAIT_LOCK → all outputs return to reset values asynchronously.
- ADC_SEQ_STAGGER_INIT_EN defined, Nti=4, init_cfg=0, start → init=8'hE4 (slices 0..3 get 0,1,2,3).
